// File: rtl/booth_mul_scheduler.sv
// Round-robin scheduler that time-shares one combinational signed multiplier
// among NREQ requesters through a two-stage (operand, result) pipeline.
module booth_mul_scheduler #(
  parameter int BITS = 8,
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_a,
  input  logic [NREQ*BITS-1:0] req_b,
  output logic [2*BITS-1:0]    mul_in,
  input  logic [2*BITS-1:0]    mul_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [2*BITS-1:0]    rsp_data,
  output logic                 busy
);

  localparam int unsigned NREQ_U = NREQ;

  logic                 op_v_q, op_v_d;
  logic [BITS-1:0]      op_a_q, op_a_d;
  logic [BITS-1:0]      op_b_q, op_b_d;
  logic [ID_W-1:0]      op_id_q, op_id_d;
  logic                 res_v_q, res_v_d;
  logic [2*BITS-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic                 res_free, op_adv, op_free;
  logic                 gnt_any;
  logic [ID_W-1:0]      gnt_idx;
  logic [BITS-1:0]      gnt_a, gnt_b;

  // Pipeline advance conditions
  always_comb begin
    res_free = !res_v_q || rsp_ready;
    op_adv   = op_v_q && res_free;
    op_free  = !op_v_q || op_adv;
  end

  // Rotating-priority scan starting at rr_ptr; at most one grant per cycle
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    if (op_free && !rst) begin
      for (int unsigned k = 0; k < NREQ_U; k++) begin
        for (int unsigned j = 0; j < NREQ_U; j++) begin
          if (!gnt_any && req_valid[j] && (j == (32'(rr_ptr_q) + k) % NREQ_U)) begin
            gnt_any      = 1'b1;
            gnt_idx      = ID_W'(j);
            req_ready[j] = 1'b1;
          end
        end
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int unsigned j = 0; j < NREQ_U; j++) begin
      if (ID_W'(j) == gnt_idx) begin
        gnt_a = req_a[j*BITS +: BITS];
        gnt_b = req_b[j*BITS +: BITS];
      end
    end
  end

  // Next-state for operand stage, result stage and round-robin pointer
  always_comb begin
    op_v_d     = op_v_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_id_d    = op_id_q;
    res_v_d    = res_v_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rr_ptr_d   = rr_ptr_q;

    if (gnt_any) begin
      op_v_d   = 1'b1;
      op_a_d   = gnt_a;
      op_b_d   = gnt_b;
      op_id_d  = gnt_idx;
      rr_ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (op_adv) begin
      op_v_d = 1'b0;
    end

    if (op_adv) begin
      res_v_d    = 1'b1;
      rsp_data_d = mul_out;
      rsp_id_d   = op_id_q;
    end else if (rsp_ready) begin
      res_v_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      op_v_q     <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_id_q    <= '0;
      res_v_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      op_v_q     <= op_v_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_id_q    <= op_id_d;
      res_v_q    <= res_v_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign mul_in    = {op_a_q, op_b_q};
  assign rsp_valid = res_v_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = op_v_q || res_v_q;

endmodule
